// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, except_type bit positions
// and the committed-exception priority decode.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT = 5'h00;
    localparam logic [4:0] EXC_SYS = 5'h08;
    localparam logic [4:0] EXC_RI  = 5'h0a;
    localparam logic [4:0] EXC_OV  = 5'h0c;
    localparam logic [4:0] EXC_TR  = 5'h0d;

    localparam int ET_SYSCALL = 8;
    localparam int ET_RI      = 9;
    localparam int ET_TRAP    = 10;
    localparam int ET_OV      = 11;
    localparam int ET_ERET    = 12;

    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exc_t;

    // eret is deliberately not decoded here; it only applies when nothing else is pending
    function automatic exc_t exc_decode(input logic [31:0] et);
        exc_t r;
        r.valid = 1'b1;
        if (et[7:0] != 8'h00)     r.code = EXC_INT;
        else if (et[ET_SYSCALL])  r.code = EXC_SYS;
        else if (et[ET_RI])       r.code = EXC_RI;
        else if (et[ET_TRAP])     r.code = EXC_TR;
        else if (et[ET_OV])       r.code = EXC_OV;
        else begin
            r.valid = 1'b0;
            r.code  = EXC_INT;
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare registers and the sticky timer interrupt.
// Timer interrupt generation is built only when CP0_TIMER_INT_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
`ifdef CP0_TIMER_INT_EN
        // a Compare write acknowledges the interrupt and wins over a match that same cycle
        timer_int_d = timer_int_q;
        if (compare_we_i)
            timer_int_d = 1'b0;
        else if ((compare_q != 32'd0) && (count_q == compare_q))
            timer_int_d = 1'b1;
`else
        timer_int_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception responder (MTC0/MFC0, exception commit, ERET).
// Optional timer interrupt: define CP0_TIMER_INT_EN (handled inside cp0_timer).
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] data_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    exc_t        exc;
    logic        unused_except_bits;

    assign unused_except_bits = ^except_type_i[31:13];

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
        .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        exc      = exc_decode(except_type_i);

        if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_d = data_i;
                CP0_EPC:    epc_d    = data_i;
                CP0_CAUSE:  cause_d[9:8] = data_i[9:8];
                default:    ;
            endcase
        end

        cause_d[15:10] = int_i;
        cause_d[15]    = int_i[5] | timer_int_o;

        // exception fields are applied after MTC0 so they override it; EXL is tested on the old Status
        if (exc.valid) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            cause_d[6:2]         = exc.code;
        end else if (except_type_i[ET_ERET]) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RESET;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        case (raddr_i)
            CP0_COUNT:   data_o = count_o;
            CP0_COMPARE: data_o = compare_o;
            CP0_STATUS:  data_o = status_q;
            CP0_CAUSE:   data_o = cause_q;
            CP0_EPC:     data_o = epc_q;
            CP0_PRID:    data_o = PRID_VALUE;
            default:     data_o = 32'd0;
        endcase
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed scenarios then randomized traffic,
// each cycle checked against a field-level reference model.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst, we_i, is_in_delayslot_i, timer_int_o;
    logic [4:0]  waddr_i, raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_i, data_o, except_type_i, pc_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .data_i            (data_i),
        .raddr_i           (raddr_i),
        .data_o            (data_o),
        .int_i             (int_i),
        .except_type_i     (except_type_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .timer_int_o       (timer_int_o)
    );

    typedef struct packed {
        logic [31:0] count, compare, status, cause, epc, data;
        logic        timer;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;

`ifdef CP0_TIMER_INT_EN
    localparam logic TIMER_ON = 1'b1;
`else
    localparam logic TIMER_ON = 1'b0;
`endif

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0001_8000;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: apply one clock of architectural rules to the model state
    task automatic model_step();
        int          prio_bit [4] = '{8, 9, 10, 11};
        logic [4:0]  prio_code[4] = '{5'h08, 5'h0a, 5'h0d, 5'h0c};
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
        logic        n_timer, hit, wr_cmp;
        logic [4:0]  code;
        exp_t        e;
        if (rst) begin
            n_count = 0; n_compare = 0; n_status = 32'h1000_0000;
            n_cause = 0; n_epc = 0; n_timer = 0;
        end else begin
            wr_cmp    = we_i && waddr_i == 5'd11;
            n_count   = (we_i && waddr_i == 5'd9) ? data_i : m_count + 1;
            n_compare = wr_cmp ? data_i : m_compare;
            n_timer   = m_timer;
            if (wr_cmp) n_timer = 0;
            else if (m_compare != 0 && m_count == m_compare) n_timer = 1;
            n_timer   = n_timer & TIMER_ON;
            n_status  = (we_i && waddr_i == 5'd12) ? data_i : m_status;
            n_epc     = (we_i && waddr_i == 5'd14) ? data_i : m_epc;
            n_cause   = m_cause;
            if (we_i && waddr_i == 5'd13) n_cause[9:8] = data_i[9:8];
            n_cause[15:10] = int_i;
            n_cause[15]    = int_i[5] | m_timer;
            hit  = (except_type_i[7:0] != 0);
            code = 5'h00;
            for (int i = 0; i < 4; i++)
                if (!hit && except_type_i[prio_bit[i]]) begin
                    hit = 1; code = prio_code[i];
                end
            if (hit) begin
                if (m_status[1] == 1'b0) begin
                    n_epc       = is_in_delayslot_i ? pc_i - 4 : pc_i;
                    n_cause[31] = is_in_delayslot_i;
                end
                n_status[1]   = 1'b1;
                n_cause[6:2]  = code;
            end else if (except_type_i[12]) begin
                n_status[1] = 1'b0;
            end
        end
        m_count = n_count; m_compare = n_compare; m_status = n_status;
        m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
        e.count = m_count; e.compare = m_compare; e.status = m_status;
        e.cause = m_cause; e.epc = m_epc; e.timer = m_timer; e.data = m_read(raddr_i);
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] d,
                         input logic [4:0] ra, input logic [5:0] irq, input logic [31:0] et,
                         input logic [31:0] pc, input logic ds);
        @(negedge clk);
        rst = r; we_i = w; waddr_i = wa; data_i = d; raddr_i = ra; int_i = irq;
        except_type_i = et; pc_i = pc; is_in_delayslot_i = ds;
        model_step();
    endtask

    task automatic idle(input int n, input logic [4:0] ra);
        repeat (n) drive(0, 0, 5'd0, 32'd0, ra, 6'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every clock the DUT presents new register outputs; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check32("sb_count",   count_o,   e.count);
                check32("sb_compare", compare_o, e.compare);
                check32("sb_status",  status_o,  e.status);
                check32("sb_cause",   cause_o,   e.cause);
                check32("sb_epc",     epc_o,     e.epc);
                check32("sb_data",    data_o,    e.data);
                check32("sb_timer",   {31'd0, timer_int_o}, {31'd0, e.timer});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  wa_tab[8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        logic        r, w, ds;
        logic [4:0]  wa;
        logic [31:0] d, et;
        int          drain;

        // reset then idle
        drive(1, 0, 5'd0, 32'd0, 5'd15, 6'd0, 32'd0, 32'd0, 0);
        idle(5, 5'd15);
        settle();
        check32("rst_count",   count_o,   32'd5);
        check32("rst_status",  status_o,  32'h1000_0000);
        check32("rst_compare", compare_o, 32'd0);
        check32("rst_cause",   cause_o,   32'd0);
        check32("rst_epc",     epc_o,     32'd0);
        check32("rst_prid",    data_o,    32'h0001_8000);

        // timer: Compare=10 written while count=3
        drive(1, 0, 5'd0, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 0);
        idle(3, 5'd9);
        drive(0, 1, 5'd11, 32'd10, 5'd11, 6'd0, 32'd0, 32'd0, 0);
        idle(12, 5'd13);
        settle();
        check32("timer_set",   {31'd0, timer_int_o}, {31'd0, TIMER_ON});
        check32("timer_ip7",   {31'd0, cause_o[15]}, {31'd0, TIMER_ON});
        drive(0, 1, 5'd11, 32'd0, 5'd11, 6'd0, 32'd0, 32'd0, 0);
        settle();
        check32("timer_clear", {31'd0, timer_int_o}, 32'd0);

        // overflow, not in delay slot
        drive(0, 0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h0000_0800, 32'h8000_0100, 0);
        settle();
        check32("ov_epc",  epc_o, 32'h8000_0100);
        check32("ov_code", {27'd0, cause_o[6:2]}, 32'h0c);
        check32("ov_exl",  {31'd0, status_o[1]}, 32'd1);

        // leave EXL, then syscall+overflow in a delay slot, then trap with EXL set
        drive(0, 0, 5'd0, 32'd0, 5'd12, 6'd0, 32'h0000_1000, 32'd0, 0);
        drive(0, 0, 5'd0, 32'd0, 5'd13, 6'd0, 32'h0000_0900, 32'h8000_0204, 1);
        settle();
        check32("sys_code", {27'd0, cause_o[6:2]}, 32'h08);
        check32("sys_bd",   {31'd0, cause_o[31]}, 32'd1);
        check32("sys_epc",  epc_o, 32'h8000_0200);
        drive(0, 0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h0000_0400, 32'h8000_0400, 0);
        settle();
        check32("trap_epc",  epc_o, 32'h8000_0200);
        check32("trap_code", {27'd0, cause_o[6:2]}, 32'h0d);

        // eret
        drive(0, 0, 5'd0, 32'd0, 5'd12, 6'd0, 32'h0000_1000, 32'h9000_0000, 0);
        settle();
        check32("eret_exl", {31'd0, status_o[1]}, 32'd0);
        check32("eret_epc", epc_o, 32'h8000_0200);

        // Cause write mask, then MTC0 Status=0 alongside an overflow
        drive(1, 0, 5'd0, 32'd0, 5'd13, 6'd0, 32'd0, 32'd0, 0);
        drive(0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0, 32'd0, 32'd0, 0);
        settle();
        check32("cause_mask", cause_o, 32'h0000_0300);
        drive(0, 1, 5'd12, 32'd0, 5'd12, 6'd0, 32'h0000_0800, 32'h8000_0010, 0);
        settle();
        check32("mtc0_exc_status", status_o, 32'h0000_0002);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(99) == 0);
            w  = ($urandom_range(99) < 35);
            wa = wa_tab[$urandom_range(7)];
            d  = $urandom;
            if (wa == 5'd11 && $urandom_range(1) == 0) d = m_count + $urandom_range(6);
            if (wa == 5'd9 && $urandom_range(3) == 0)  d = 32'hFFFF_FFFD;
            et = 32'd0;
            if ($urandom_range(99) < 20) begin
                et[12:8] = 5'($urandom);
                if ($urandom_range(3) == 0) et[7:0] = 8'($urandom);
                if ($urandom_range(3) == 0) et[31:13] = 19'($urandom);
            end
            ds = 1'($urandom);
            drive(r, w, wa, d, 5'($urandom), 6'($urandom), et, $urandom & 32'hFFFF_FFFC, ds);
        end
        idle(2, 5'd9);

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            #3;
            drain++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
